// File: rtl/led_band_fc_setter_if.sv
// Pin bundle between the host/driver side and the FC setter.
// Latency: none, wires only.
// Backpressure: none; every line is a free-running level or clock.
interface led_band_fc_setter_if;
    logic SCLK;
    logic LAT;
    logic spi_clk;
    logic spi_data;
    logic en;
    logic SOUT;

    // Host / driver side: drives the clocks, latch and serial data in.
    modport master (
        output SCLK,
        output LAT,
        output spi_clk,
        output spi_data,
        input  en,
        input  SOUT
    );

    // Setter side: watches the lines and drives SIN (SOUT) and en.
    modport slave (
        input  SCLK,
        input  LAT,
        input  spi_clk,
        input  spi_data,
        output en,
        output SOUT
    );
endinterface

// File: rtl/led_band_fc_setter.sv
// Receives an FC word over a bit-serial host link and shifts it MSB-first to a TLC5957 SIN.
// Latency: FC update 3 clk after synced spi_clk rise; shift 3-4 clk after each SCLK rise.
// Backpressure: none; all links are externally paced, and words arriving mid-shift wait in FC.
module led_band_fc_setter #(
    parameter int FC_WIDTH      = 48,
    parameter int FCWRTEN_EDGES = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    led_band_fc_setter_if.slave  bus
);
    localparam int BCW = $clog2(FC_WIDTH);
    localparam int ACW = $clog2(FCWRTEN_EDGES + 1);
    localparam logic [BCW-1:0] LAST_BIT  = BCW'(FC_WIDTH - 1);
    localparam logic [ACW-1:0] ARM_EDGES = ACW'(FCWRTEN_EDGES);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [1:0]          sclk_sync, lat_sync, spi_clk_sync, spi_dat_sync;
    logic                sclk_prev, lat_prev, spi_clk_prev;
    logic                sclk_s, lat_s, spi_clk_s, spi_dat_s;
    logic                sclk_rise, spi_rise, lat_fall;
    logic                sclk_tick;
    logic [FC_WIDTH-1:0] rx, rx_nxt, FC, shift_reg;
    logic [BCW-1:0]      bit_cnt, shift_cnt;
    logic [ACW-1:0]      arm_cnt;
    logic                en_int;

    assign sclk_s    = sclk_sync[1];
    assign lat_s     = lat_sync[1];
    assign spi_clk_s = spi_clk_sync[1];
    assign spi_dat_s = spi_dat_sync[1];

    assign sclk_rise = sclk_s & ~sclk_prev;
    assign spi_rise  = spi_clk_s & ~spi_clk_prev;
    assign lat_fall  = lat_prev & ~lat_s;
    assign rx_nxt    = {rx[FC_WIDTH-2:0], spi_dat_s};

    // Two-flop synchronisers plus one history flop per line for edge detection.
    // sclk_tick delays the SCLK rise by one clk so the shift lands 3-4 clk after
    // the edge, giving the driver hold time on SIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync    <= '0;
            lat_sync     <= '0;
            spi_clk_sync <= '0;
            spi_dat_sync <= '0;
            sclk_prev    <= 1'b0;
            lat_prev     <= 1'b0;
            spi_clk_prev <= 1'b0;
            sclk_tick    <= 1'b0;
        end else begin
            sclk_sync    <= {sclk_sync[0], bus.SCLK};
            lat_sync     <= {lat_sync[0], bus.LAT};
            spi_clk_sync <= {spi_clk_sync[0], bus.spi_clk};
            spi_dat_sync <= {spi_dat_sync[0], bus.spi_data};
            sclk_prev    <= sclk_s;
            lat_prev     <= lat_s;
            spi_clk_prev <= spi_clk_s;
            sclk_tick    <= sclk_rise;
        end
    end

    // Host receive: back-to-back 48-bit frames; each completed frame lands in FC.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx      <= '0;
            FC      <= '0;
            bit_cnt <= '0;
        end else if (spi_rise) begin
            rx <= rx_nxt;
            if (bit_cnt == LAST_BIT) begin
                FC      <= rx_nxt;
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    // FCWRTEN detector: SCLK rises seen with LAT high, saturating, cleared by LAT low.
    always_ff @(posedge clk) begin
        if (rst) begin
            arm_cnt <= '0;
        end else if (!lat_s) begin
            arm_cnt <= '0;
        end else if (sclk_tick && state == IDLE && arm_cnt != ARM_EDGES) begin
            arm_cnt <= arm_cnt + 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: arm on LAT fall after a long enough FCWRTEN, leave after the last bit.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (lat_fall && arm_cnt >= ARM_EDGES) state_nxt = SHIFT;
            SHIFT: if (sclk_tick && shift_cnt == LAST_BIT) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        en_int = 1'b0;
        if (state == SHIFT) en_int = 1'b1;
    end

    // Shift register tracks FC while idle, then walks out one bit per SCLK rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= '0;
            shift_cnt <= '0;
        end else if (state == SHIFT) begin
            if (sclk_tick) begin
                shift_reg <= {shift_reg[FC_WIDTH-2:0], 1'b0};
                shift_cnt <= (shift_cnt == LAST_BIT) ? '0 : shift_cnt + 1'b1;
            end
        end else begin
            shift_reg <= FC;
            shift_cnt <= '0;
        end
    end

    assign bus.en   = en_int;
    assign bus.SOUT = shift_reg[FC_WIDTH-1];
endmodule

// File: tb/tb_led_band_fc_setter.sv
module tb_led_band_fc_setter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    led_band_fc_setter_if bus ();

    led_band_fc_setter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model of the host link: bits received so far and the last full word.
    bit          rx_bits[$];
    logic [47:0] exp_fc = '0;

    // TLC5957 model: SIN sampled on SCLK rise; WRTFC (LAT high for 5 rises) latches FC.
    logic [47:0] drv_sr = '0;
    logic [47:0] drv_fc = '0;
    int          lat_hi_rises = 0;
    int          en_rises = 0;
    logic        lat_was = 1'b0;

    always @(posedge bus.SCLK) begin
        drv_sr = {drv_sr[46:0], bus.SOUT};
        if (bus.LAT === 1'b1) lat_hi_rises = lat_was ? lat_hi_rises + 1 : 1;
        lat_was = bus.LAT;
        if (bus.en === 1'b1) en_rises++;
    end

    always @(negedge bus.LAT) begin
        if (lat_hi_rises == 5) drv_fc = drv_sr;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // n SCLK periods of 10 clk; LAT changes only while SCLK is low.
    task automatic sclk_run(input int n, input logic lat_v);
        for (int i = 0; i < n; i++) begin
            bus.LAT = lat_v;
            wait_clk(5);
            bus.SCLK = 1'b1;
            wait_clk(5);
            bus.SCLK = 1'b0;
        end
    endtask

    task automatic fc_write(input int hi1, input int lo1, input int hi2, input int lo2);
        sclk_run(hi1, 1'b1);
        sclk_run(lo1, 1'b0);
        sclk_run(hi2, 1'b1);
        sclk_run(lo2, 1'b0);
    endtask

    task automatic send_word(input logic [47:0] w);
        logic [47:0] acc;
        for (int i = 47; i >= 0; i--) begin
            bus.spi_data = w[i];
            wait_clk(2);
            bus.spi_clk = 1'b1;
            wait_clk(10);
            bus.spi_clk = 1'b0;
            wait_clk(4);
            rx_bits.push_back(w[i]);
            if (rx_bits.size() == 48) begin
                acc = '0;
                foreach (rx_bits[j]) acc = {acc[46:0], rx_bits[j]};
                exp_fc = acc;
                rx_bits.delete();
            end
        end
    endtask

    task automatic model_reset();
        rx_bits.delete();
        exp_fc = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        wait_clk(20);
        n_checks++;
        if (bus.en !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b expected 0", bus.en); end
        n_checks++;
        if (bus.SOUT !== 1'b0) begin n_fail++; $display("FAIL reset_sout: got %b expected 0", bus.SOUT); end
        n_checks++;
        if (dut.FC !== 48'h0) begin n_fail++; $display("FAIL reset_fc: got %h expected 0", dut.FC); end
        rst = 1'b0;
        wait_clk(2);
    endtask

    task automatic test_host_load(input logic [47:0] w, input string tag);
        send_word(w);
        wait_clk(2);
        n_checks++;
        if (dut.FC !== exp_fc) begin n_fail++; $display("FAIL %s_fc: got %h expected %h", tag, dut.FC, exp_fc); end
        n_checks++;
        if (bus.SOUT !== exp_fc[47]) begin n_fail++; $display("FAIL %s_sout: got %b expected %b", tag, bus.SOUT, exp_fc[47]); end
    endtask

    task automatic test_full_write(input int fcwrten, input string tag);
        int          e0;
        logic [47:0] armed;
        armed = exp_fc;
        e0 = en_rises;
        fc_write(fcwrten, 43, 5, 2);
        n_checks++;
        if (drv_fc !== armed) begin n_fail++; $display("FAIL %s_latch: got %h expected %h", tag, drv_fc, armed); end
        n_checks++;
        if (en_rises - e0 != 48) begin n_fail++; $display("FAIL %s_en_edges: got %0d expected 48", tag, en_rises - e0); end
    endtask

    task automatic test_short_fcwrten(input int n);
        int e0;
        e0 = en_rises;
        sclk_run(n, 1'b1);
        sclk_run(48, 1'b0);
        n_checks++;
        if (en_rises - e0 != 0) begin n_fail++; $display("FAIL short%0d_en: got %0d en edges expected 0", n, en_rises - e0); end
        n_checks++;
        if (drv_sr !== {48{exp_fc[47]}}) begin n_fail++; $display("FAIL short%0d_sin: got %h expected %h", n, drv_sr, {48{exp_fc[47]}}); end
        n_checks++;
        if (dut.FC !== exp_fc) begin n_fail++; $display("FAIL short%0d_fc: got %h expected %h", n, dut.FC, exp_fc); end
    endtask

    task automatic test_fc_update_during_shift();
        logic [47:0] armed;
        logic        upd_en;
        int          e0;
        armed = exp_fc;
        e0 = en_rises;
        upd_en = 1'b0;
        fork
            begin
                send_word(48'h123456789abc);
                upd_en = bus.en;
            end
            begin
                wait_clk(400);
                fc_write(15, 43, 5, 2);
            end
        join
        n_checks++;
        if (upd_en !== 1'b1) begin n_fail++; $display("FAIL upd_in_shift_en: got %b expected 1", upd_en); end
        n_checks++;
        if (drv_fc !== armed) begin n_fail++; $display("FAIL upd_latch: got %h expected %h", drv_fc, armed); end
        n_checks++;
        if (en_rises - e0 != 48) begin n_fail++; $display("FAIL upd_en_edges: got %0d expected 48", en_rises - e0); end
        n_checks++;
        if (dut.FC !== exp_fc) begin n_fail++; $display("FAIL upd_fc: got %h expected %h", dut.FC, exp_fc); end
        n_checks++;
        if (bus.SOUT !== exp_fc[47]) begin n_fail++; $display("FAIL upd_sout: got %b expected %b", bus.SOUT, exp_fc[47]); end
    endtask

    task automatic test_reset_mid_shift();
        logic [63:0] r;
        sclk_run(15, 1'b1);
        sclk_run(20, 1'b0);
        n_checks++;
        if (bus.en !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_en: got %b expected 1", bus.en); end
        test_reset();
        r = {$urandom, $urandom};
        test_host_load(r[47:0], "midrst_load");
        test_full_write(15, "midrst_write");
    endtask

    task automatic test_random(input int iters);
        logic [63:0] r;
        for (int k = 0; k < iters; k++) begin
            r = {$urandom, $urandom};
            test_host_load(r[47:0], "rnd_load");
            test_full_write($urandom_range(15, 24), "rnd_write");
        end
    endtask

    initial begin
        bus.SCLK = 1'b0;
        bus.LAT = 1'b0;
        bus.spi_clk = 1'b0;
        bus.spi_data = 1'b0;
        test_reset();
        test_host_load(48'hec020100804e, "load");
        n_checks++;
        if (exp_fc !== dut.FC || dut.FC !== 48'hec020100804e) begin
            n_fail++; $display("FAIL load_const: got %h expected ec020100804e", dut.FC);
        end
        test_full_write(15, "write");
        test_short_fcwrten(14);
        test_short_fcwrten($urandom_range(1, 13));
        test_fc_update_during_shift();
        test_full_write(20, "saturate");
        test_reset_mid_shift();
        test_random(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
